frame_stream_packer: RTL
========================

FRAME_STREAM_PACKER -- requirements
Module: frame_stream_packer

Interface
REQ-001 Parameter DATA_SIZE, 12, sample width in bits; legal range 1..16.
REQ-002 Parameter CH_NUM, 4, number of input sample channels.
REQ-003 Parameter CH_SIZE, 2, width of the channel select; clog2(CH_NUM), minimum 1.
REQ-004 Parameter LENGTH, 32768, samples per frame; must be even.
REQ-005 Parameter LENGTH_SIZE, 15, width of the sample and word counters.
REQ-006 Parameter FIFO_ADDR, 4, FIFO address width; depth is 2**FIFO_ADDR words.
REQ-007 Port: clk  in  1  the single clock; every register updates on its rising edge.
REQ-008 Port: rst  in  1  reset, synchronous and active-high.
REQ-009 Port: Start  in  1  one-cycle frame-start request.
REQ-010 Port: ChSel  in  CH_SIZE  channel to capture; sampled on the cycle Start is accepted.
REQ-011 Port: Pack  in  1  pack mode (1 = two samples per word); sampled on the cycle Start is accepted.
REQ-012 Port: Valid  in  CH_NUM  per-channel sample strobe.
REQ-013 Port: Data  in  CH_NUM*DATA_SIZE  samples, channel i at bits [i*DATA_SIZE +: DATA_SIZE].
REQ-014 Port: M_AXIS_tdata  out  32  stream data.
REQ-015 Port: M_AXIS_tkeep  out  4  byte enables; constant 4'hF.
REQ-016 Port: M_AXIS_tlast  out  1  marks the last beat of a frame.
REQ-017 Port: M_AXIS_tvalid  out  1  stream valid.
REQ-018 Port: M_AXIS_tready  in  1  stream ready.
REQ-019 Port: Busy  out  1  high while a frame is in progress.
REQ-020 Port: Done  out  1  one-cycle pulse when the frame's last beat completes.
REQ-021 Port: Overflow  out  1  sticky flag: at least one word was dropped this frame.
REQ-022 Port: DropCount  out  16  number of words dropped this frame; saturates at 16'hFFFF.

Function
REQ-023 FSM states and transitions:
- IDLE -> CAPT on Start; ChSel and Pack latch on the same edge.
- CAPT -> DRAIN when the last word of the frame has been written to the FIFO.
- DRAIN -> IDLE when the tlast beat handshakes (tvalid & tready).
REQ-024 Start is ignored outside IDLE.
REQ-025 Accepting Start clears Overflow, DropCount, the word counter and the pack register.
REQ-026 Busy is high in CAPT and DRAIN and low in IDLE.
REQ-027 In CAPT, a sample is taken in any cycle where Valid[ChSel_latched] = 1; samples on other channels are ignored.
REQ-028 Word forming by mode:
- Pack = 0: every sample forms one word {zeros, sample}.
- Pack = 1: the first sample is held in the pack register; the second forms {zeros, s2[15:0 ext], zeros, s1} with s1 in bits [15:0] and s2 in bits [31:16], each zero-extended to 16 bits.
REQ-029 Words per frame: WORDS = LENGTH when Pack = 0, and LENGTH/2 when Pack = 1.
REQ-030 A formed word is written to the FIFO together with a tlast bit; tlast = 1 only on word number WORDS-1.
REQ-031 The word counter advances only on successful FIFO writes, so each frame emits exactly WORDS beats and tlast is never lost.
REQ-032 Overflow handling: a word formed while the FIFO is full and no read happens in the same cycle is dropped.
- Overflow is set to 1.
- DropCount is incremented by 1, saturating.
- In pack mode, both samples of the dropped word are lost.
REQ-033 A simultaneous FIFO read and write when the FIFO is full is legal and is not a drop.
REQ-034 AXIS rules:
- tvalid = FIFO not empty.
- tdata and tlast must not change while tvalid = 1 and tready = 0.
- A beat transfers on tvalid & tready.
REQ-035 Latency: a word completed in cycle t with the FIFO empty gives tvalid = 1 in cycle t+2.
REQ-036 Done pulses in the cycle after the tlast handshake, which is the cycle in which the FSM enters IDLE.
REQ-037 Overflow and DropCount hold their values in IDLE until the next Start is accepted.

Reset
REQ-038 While rst = 1, every register clears on the next edge:
- FSM goes to IDLE.
- FIFO empties.
- M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tdata, Busy, Done, Overflow and DropCount all go to 0.
REQ-039 Reset in the middle of a frame discards all buffered words, and no tlast is issued for that frame.
REQ-040 rst takes priority over Start in the same cycle.

Verification
REQ-041 Pack = 0, LENGTH = 8, tready = 1, ChSel = 2, Valid[2] on every cycle -> 8 beats with tdata equal to the samples, tlast on beat 8 only, Done 1 cycle after beat 8, DropCount = 0.
REQ-042 Pack = 1, LENGTH = 8, samples 1..8 -> 4 beats 32'h0002_0001, 0004_0003, 0006_0005, 0008_0007, tlast on the 4th beat.
REQ-043 FIFO_ADDR = 2, tready = 0 for the first 10 samples of a 16-sample frame with Pack = 0, then tready = 1 -> Overflow = 1 and DropCount = 6 (4 stored, 6 dropped), exactly 16 beats total, tlast on beat 16.
REQ-044 Random tready with a 30% stall rate -> no data change while stalled, and beat count equals WORDS.
REQ-045 rst asserted mid-frame -> next cycle tvalid = 0 and Busy = 0; a new Start gives a clean frame with DropCount = 0.
REQ-046 Start pulsed during CAPT, and Valid on a non-selected channel -> both have no effect on beat count or data.

Source files
------------

// File: rtl/frame_stream_packer.sv
// Frame stream packer: captures samples from one selected channel, optionally
// packs two samples per 32-bit word, buffers words in a small FIFO and emits
// them as an AXI-Stream frame with tlast on the final word. Words that find
// the FIFO full are dropped and counted, but the frame still ends on exactly
// WORDS successfully buffered words.
module frame_stream_packer #(
  parameter int DATA_SIZE   = 12,
  parameter int CH_NUM      = 4,
  parameter int CH_SIZE     = 2,
  parameter int LENGTH      = 32768,
  parameter int LENGTH_SIZE = 15,
  parameter int FIFO_ADDR   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        Start,
  input  logic [CH_SIZE-1:0]          ChSel,
  input  logic                        Pack,
  input  logic [CH_NUM-1:0]           Valid,
  input  logic [CH_NUM*DATA_SIZE-1:0] Data,
  output logic [31:0]                 M_AXIS_tdata,
  output logic [3:0]                  M_AXIS_tkeep,
  output logic                        M_AXIS_tlast,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output logic                        Busy,
  output logic                        Done,
  output logic                        Overflow,
  output logic [15:0]                 DropCount
);

  localparam int DEPTH = 2 ** FIFO_ADDR;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAPT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CH_SIZE-1:0]     ch_q, ch_d;
  logic                   pack_q, pack_d;
  logic                   half_q, half_d;
  logic [15:0]            hold_q, hold_d;
  logic                   stage_vld_q, stage_vld_d;
  logic [31:0]            stage_word_q, stage_word_d;
  logic [LENGTH_SIZE-1:0] wcnt_q, wcnt_d;
  logic [FIFO_ADDR-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_ADDR:0]     cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [15:0]            drop_q, drop_d;
  logic                   done_q, done_d;
  logic [32:0]            mem_q [DEPTH];

  logic                   sel_valid_s;
  logic [DATA_SIZE-1:0]   sel_sample_s;
  logic [32:0]            head_s;
  logic                   fifo_full_s;
  logic                   rd_s;
  logic                   wr_try_s;
  logic                   wr_s;
  logic                   drop_s;
  logic                   last_s;
  logic                   take_s;
  logic [LENGTH_SIZE-1:0] words_m1_s;

  assign sel_valid_s  = Valid[ch_q];
  assign sel_sample_s = Data[int'(ch_q)*DATA_SIZE +: DATA_SIZE];
  assign head_s       = mem_q[rd_ptr_q];
  assign fifo_full_s  = (cnt_q == (FIFO_ADDR+1)'(DEPTH));
  assign rd_s         = M_AXIS_tvalid & M_AXIS_tready;
  // The staged word is only committed while capturing; anything staged after
  // the final word is silently discarded.
  assign wr_try_s     = stage_vld_q & (state_q == CAPT);
  assign wr_s         = wr_try_s & (~fifo_full_s | rd_s);
  assign drop_s       = wr_try_s & fifo_full_s & ~rd_s;
  assign words_m1_s   = pack_q ? LENGTH_SIZE'(LENGTH/2 - 1) : LENGTH_SIZE'(LENGTH - 1);
  assign last_s       = (wcnt_q == words_m1_s);
  assign take_s       = (state_q == CAPT) & sel_valid_s & ~(wr_s & last_s);

  // Stream outputs decode directly from FIFO registers so data is stable under stall.
  assign M_AXIS_tvalid = (cnt_q != (FIFO_ADDR+1)'(0));
  assign M_AXIS_tdata  = M_AXIS_tvalid ? head_s[31:0] : 32'd0;
  assign M_AXIS_tlast  = M_AXIS_tvalid & head_s[32];
  assign M_AXIS_tkeep  = 4'hF;
  assign Busy          = (state_q != IDLE);
  assign Done          = done_q;
  assign Overflow      = ovf_q;
  assign DropCount     = drop_q;

  // Next-state logic for the FSM, word forming, FIFO pointers and drop accounting.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    pack_d       = pack_q;
    half_d       = half_q;
    hold_d       = hold_q;
    stage_vld_d  = 1'b0;
    stage_word_d = stage_word_q;
    wcnt_d       = wcnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    drop_d       = drop_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = CAPT;
          ch_d    = ChSel;
          pack_d  = Pack;
          half_d  = 1'b0;
          hold_d  = 16'd0;
          wcnt_d  = '0;
          ovf_d   = 1'b0;
          drop_d  = 16'd0;
        end else begin
          state_d = IDLE;
        end
      end
      CAPT: begin
        if (wr_s && last_s) begin
          state_d = DRAIN;
        end else begin
          state_d = CAPT;
        end
      end
      DRAIN: begin
        if (rd_s && M_AXIS_tlast) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Word forming: unpacked words go straight to the stage, packed words
    // pair the held first sample (low half) with the second (high half).
    if (take_s) begin
      if (!pack_q) begin
        stage_word_d = 32'(sel_sample_s);
        stage_vld_d  = 1'b1;
      end else if (!half_q) begin
        hold_d = 16'(sel_sample_s);
        half_d = 1'b1;
      end else begin
        stage_word_d = {16'(sel_sample_s), hold_q};
        stage_vld_d  = 1'b1;
        half_d       = 1'b0;
      end
    end else begin
      stage_word_d = stage_word_q;
    end

    if (wr_s) begin
      wcnt_d   = wcnt_q + LENGTH_SIZE'(1);
      wr_ptr_d = wr_ptr_q + FIFO_ADDR'(1);
    end else begin
      wcnt_d   = wcnt_d;
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_s) begin
      rd_ptr_d = rd_ptr_q + FIFO_ADDR'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_s, rd_s})
      2'b10:   cnt_d = cnt_q + (FIFO_ADDR+1)'(1);
      2'b01:   cnt_d = cnt_q - (FIFO_ADDR+1)'(1);
      default: cnt_d = cnt_q;
    endcase

    if (drop_s) begin
      ovf_d = 1'b1;
      if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end else begin
        drop_d = drop_q;
      end
    end else begin
      ovf_d = ovf_d;
    end
  end

  // State and control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ch_q         <= '0;
      pack_q       <= 1'b0;
      half_q       <= 1'b0;
      hold_q       <= 16'd0;
      stage_vld_q  <= 1'b0;
      stage_word_q <= 32'd0;
      wcnt_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      drop_q       <= 16'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      pack_q       <= pack_d;
      half_q       <= half_d;
      hold_q       <= hold_d;
      stage_vld_q  <= stage_vld_d;
      stage_word_q <= stage_word_d;
      wcnt_q       <= wcnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      drop_q       <= drop_d;
      done_q       <= done_d;
    end
  end

  // FIFO storage: {tlast, data}; contents are qualified by the count, so no reset.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= {last_s, stage_word_q};
    end
  end

endmodule
